inertial_delay_filter: RTL and testbench
========================================

INERTIAL_DELAY_FILTER -- requirements
Module: inertial_delay_filter

Interface
REQ-001 The block SHALL have parameter DELAY, default 10: number of consecutive clock samples a new input level must hold before it reaches y; legal range 1..2^16-1.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the rejected-glitch counter; legal range 1..32.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port a, input, 1 bit: raw input level, already synchronous to clk.
REQ-006 The block SHALL have port glitch_clr, input, 1 bit: synchronous clear of glitch_cnt.
REQ-007 The block SHALL have port y, output, 1 bit: filtered (inertially delayed) level, registered.
REQ-008 The block SHALL have port y_rise, output, 1 bit: one-cycle pulse coincident with y going 0->1.
REQ-009 The block SHALL have port y_fall, output, 1 bit: one-cycle pulse coincident with y going 1->0.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a pending level change is being qualified.
REQ-011 The block SHALL have port glitch_cnt, output, CNT_W bits: saturating count of rejected pulses.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (sampled a equals y) and PEND (sampled a differs from y, qualifying), plus a qualification counter wide enough for DELAY-1.
REQ-013 In IDLE, the edge at which sampled a != y is edge 0; if DELAY=1, y SHALL take a at edge 0 and the FSM SHALL stay in IDLE; otherwise the FSM SHALL enter PEND with counter = 1.
REQ-014 In PEND, at each edge with sampled a != y, the counter SHALL increment; at the edge where the counter equals DELAY-1, y SHALL take a, the counter SHALL clear, and the FSM SHALL return to IDLE.
REQ-015 Net latency: a level held for exactly DELAY consecutive samples (edges 0..DELAY-1) SHALL appear on y after edge DELAY-1; a level held for fewer SHALL never appear on y.
REQ-016 In PEND, an edge with sampled a == y SHALL be a glitch: FSM to IDLE, counter cleared, y unchanged, glitch_cnt incremented by 1.
REQ-017 glitch_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 glitch_clr SHALL set glitch_cnt to 0 at the next edge; when it coincides with a glitch, clear SHALL win (result 0).
REQ-019 y_rise and y_fall SHALL be registered and high for exactly the one cycle following the edge at which y changes; never both high.
REQ-020 busy SHALL equal (state == PEND), registered; busy is high for DELAY-1 cycles on a qualified change and is never high when DELAY=1.
REQ-021 A glitch in PEND SHALL NOT start a new qualification in the same edge; a following edge with a != y starts at edge 0 again.

Reset
REQ-022 With rst high at an edge: y=0, y_rise=0, y_fall=0, busy=0, glitch_cnt=0, counter=0, FSM=IDLE; rst SHALL take priority over all other inputs, including an in-progress PEND, which is abandoned without counting a glitch.
REQ-023 After rst deasserts with a=1, the block SHALL treat it as a normal pending change: y rises after DELAY consecutive samples of 1.

Verification
REQ-024 DELAY=4, CNT_W=8: rst high 2 cycles, a=0 -> y=0, busy=0, y_rise=0, y_fall=0, glitch_cnt=0.
REQ-025 DELAY=4: a 0->1 held 10 cycles -> y=1 after 4th sample edge of 1, y_rise high exactly 1 cycle, busy high exactly 3 cycles; then a 1->0 held -> y_fall 1 cycle, y=0 after 4 samples.
REQ-026 DELAY=4: a high for 3 cycles then 0 -> y stays 0, no strobes, glitch_cnt=1; glitch_clr pulse -> glitch_cnt=0.
REQ-027 DELAY=4, CNT_W=8: 300 back-to-back 1-cycle pulses -> glitch_cnt=255 and holds; glitch_clr coincident with a glitch -> glitch_cnt=0.
REQ-028 DELAY=4: rst asserted on 2nd cycle of PEND with y=0 -> after edge y=0, busy=0, glitch_cnt=0; with a still 1 after release, y=1 after 4 samples.
REQ-029 DELAY=1: random a sequence -> y equals a delayed by one cycle, busy never high, glitch_cnt stays 0.

Source files
------------

// File: rtl/inertial_delay_filter.sv
// Inertial delay filter: a new input level must persist for DELAY consecutive
// clock samples before it propagates to y; shorter pulses are counted as glitches.
module inertial_delay_filter #(
    parameter int unsigned DELAY = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             glitch_clr,
    output logic             y,
    output logic             y_rise,
    output logic             y_fall,
    output logic             busy,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int unsigned      QW   = (DELAY > 2) ? $clog2(DELAY) : 1;
    localparam logic [QW-1:0]    LAST = QW'(DELAY - 1);
    localparam logic [CNT_W-1:0] GMAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [QW-1:0]    qcnt;
    logic [QW-1:0]    qcnt_nx;
    logic             y_nx;
    logic             glitch;
    logic [CNT_W-1:0] gcnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            qcnt       <= '0;
            y          <= 1'b0;
            y_rise     <= 1'b0;
            y_fall     <= 1'b0;
            busy       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state      <= state_nx;
            qcnt       <= qcnt_nx;
            y          <= y_nx;
            y_rise     <= y_nx & ~y;
            y_fall     <= ~y_nx & y;
            busy       <= (state_nx == PEND);
            glitch_cnt <= gcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        qcnt_nx  = qcnt;
        y_nx     = y;
        glitch   = 1'b0;

        unique case (state)
            IDLE: begin
                if (a != y) begin
                    // With DELAY=1 the first differing sample already qualifies.
                    if (DELAY == 1) begin
                        y_nx = a;
                    end else begin
                        state_nx = PEND;
                        qcnt_nx  = QW'(1);
                    end
                end
            end
            PEND: begin
                if (a != y) begin
                    if (qcnt == LAST) begin
                        y_nx     = a;
                        qcnt_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        qcnt_nx = qcnt + 1'b1;
                    end
                end else begin
                    // Input fell back before qualifying; no new qualification this edge.
                    glitch   = 1'b1;
                    qcnt_nx  = '0;
                    state_nx = IDLE;
                end
            end
        endcase

        if (glitch_clr) begin
            gcnt_nx = '0;
        end else if (glitch && (glitch_cnt != GMAX)) begin
            gcnt_nx = glitch_cnt + 1'b1;
        end else begin
            gcnt_nx = glitch_cnt;
        end
    end

endmodule

// File: tb/tb_inertial_delay_filter.sv
// Bench for inertial_delay_filter: DELAY=4 and DELAY=1 instances checked every
// cycle against a run-length model, plus hand-computed scenario expectations.
module tb_inertial_delay_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       a1;
    logic       glitch_clr;

    logic       y, y_rise, y_fall, busy;
    logic [7:0] glitch_cnt;
    logic       y1, y_rise1, y_fall1, busy1;
    logic [7:0] glitch_cnt1;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    bit busy1_seen = 1'b0;

    always #5 clk = ~clk;

    inertial_delay_filter #(.DELAY(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .glitch_clr(glitch_clr),
        .y(y), .y_rise(y_rise), .y_fall(y_fall), .busy(busy),
        .glitch_cnt(glitch_cnt)
    );

    inertial_delay_filter #(.DELAY(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .glitch_clr(glitch_clr),
        .y(y1), .y_rise(y_rise1), .y_fall(y_fall1), .busy(busy1),
        .glitch_cnt(glitch_cnt1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level change is a run of samples differing from y; a run reaching
    // DELAY is accepted, a run cut short is one glitch.
    int dl[2] = '{4, 1};
    int m_run[2];
    int m_g[2];
    bit m_y[2], m_r[2], m_f[2], m_b[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ak;
            bit prev;
            bit gl;
            ak   = (k == 0) ? a : a1;
            prev = m_y[k];
            gl   = 1'b0;
            if (rst) begin
                m_run[k] = 0; m_g[k] = 0;
                m_y[k] = 0; m_r[k] = 0; m_f[k] = 0; m_b[k] = 0;
            end else begin
                if (ak != m_y[k]) begin
                    m_run[k]++;
                    if (m_run[k] == dl[k]) begin
                        m_y[k]   = ak;
                        m_run[k] = 0;
                    end
                end else begin
                    if (m_run[k] > 0) gl = 1'b1;
                    m_run[k] = 0;
                end
                m_r[k] = m_y[k] & ~prev;
                m_f[k] = ~m_y[k] & prev;
                m_b[k] = (m_run[k] > 0);
                if (glitch_clr) m_g[k] = 0;
                else if (gl && m_g[k] < 255) m_g[k]++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("d4_y",      int'(y),          int'(m_y[0]));
            check("d4_rise",   int'(y_rise),     int'(m_r[0]));
            check("d4_fall",   int'(y_fall),     int'(m_f[0]));
            check("d4_busy",   int'(busy),       int'(m_b[0]));
            check("d4_gcnt",   int'(glitch_cnt), m_g[0]);
            check("d1_y",      int'(y1),          int'(m_y[1]));
            check("d1_rise",   int'(y_rise1),     int'(m_r[1]));
            check("d1_fall",   int'(y_fall1),     int'(m_f[1]));
            check("d1_busy",   int'(busy1),       int'(m_b[1]));
            check("d1_gcnt",   int'(glitch_cnt1), m_g[1]);
            if (busy1 === 1'b1) busy1_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        a1 = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int first_y;
        int busy_n;
        int rise_n;
        int fall_n;
        bit y_seen;

        rst = 1'b1; a = 1'b0; a1 = 1'b0; glitch_clr = 1'b0;
        repeat (2) tick();
        check("rst_y",    int'(y),          0);
        check("rst_busy", int'(busy),       0);
        check("rst_rise", int'(y_rise),     0);
        check("rst_fall", int'(y_fall),     0);
        check("rst_gcnt", int'(glitch_cnt), 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) tick();

        // Qualified rise: y after 4th sample, one rise strobe, busy 3 cycles
        a = 1'b1;
        first_y = -1; busy_n = 0; rise_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (y === 1'b1 && first_y < 0) first_y = i;
            if (busy === 1'b1) busy_n++;
            if (y_rise === 1'b1) rise_n++;
        end
        check("rise_lat",  first_y, 3);
        check("rise_busy", busy_n,  3);
        check("rise_strb", rise_n,  1);

        // Qualified fall
        a = 1'b0;
        first_y = -1; fall_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (y === 1'b0 && first_y < 0) first_y = i;
            if (y_fall === 1'b1) fall_n++;
        end
        check("fall_lat",  first_y, 3);
        check("fall_strb", fall_n,  1);

        // Three-sample pulse is rejected
        y_seen = 1'b0; rise_n = 0;
        a = 1'b1;
        repeat (3) begin
            tick();
            if (y !== 1'b0) y_seen = 1'b1;
            if (y_rise !== 1'b0) rise_n++;
        end
        a = 1'b0;
        repeat (4) begin
            tick();
            if (y !== 1'b0) y_seen = 1'b1;
            if (y_rise !== 1'b0) rise_n++;
        end
        check("glitch_y",    int'(y_seen),     0);
        check("glitch_strb", rise_n,           0);
        check("glitch_cnt1", int'(glitch_cnt), 1);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        check("clr_gcnt", int'(glitch_cnt), 0);

        // 300 single-cycle pulses saturate the counter
        for (int i = 0; i < 300; i++) begin
            a = 1'b1; tick();
            a = 1'b0; tick();
        end
        check("sat_gcnt", int'(glitch_cnt), 255);
        repeat (5) begin
            a = 1'b1; tick();
            a = 1'b0; tick();
        end
        check("sat_hold", int'(glitch_cnt), 255);
        a = 1'b1; tick();
        a = 1'b0; glitch_clr = 1'b1; tick();
        glitch_clr = 1'b0;
        check("clr_win", int'(glitch_cnt), 0);
        repeat (3) tick();

        // Reset during PEND abandons qualification without a glitch
        a = 1'b1;
        repeat (2) tick();
        check("pend_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("prst_y",    int'(y),          0);
        check("prst_busy", int'(busy),       0);
        check("prst_gcnt", int'(glitch_cnt), 0);
        first_y = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (y === 1'b1 && first_y < 0) first_y = i;
        end
        check("prst_lat", first_y, 3);

        repeat (40) tick();
        check("d1_busy_never", int'(busy1_seen),  0);
        check("d1_gcnt_zero",  int'(glitch_cnt1), 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
